// File: rtl/note_key_debouncer.sv
// rtl/note_key_debouncer.sv - debounces eight raw piano keys into one 4-bit note code
// Two-flop synchronizer, lowest-key-wins encoder and a four-state debounce FSM.
module note_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] keys,
  output logic [3:0] note,
  output logic       note_strobe,
  output logic       multi_key
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1_q;
  logic [7:0]       sync2_q;
  logic [3:0]       raw_code;
  logic [3:0]       ones;
  logic             multi_d;
  logic             multi_q;
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cand_q;
  logic [3:0]       cand_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       note_q;
  logic [3:0]       note_d;
  logic             strobe_q;
  logic             strobe_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      multi_q <= 1'b0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      multi_q <= multi_d;
    end
  end

  // Scan from the top so the lowest set key is the last one written.
  always_comb begin
    raw_code = '0;
    ones     = '0;
    for (int i = 7; i >= 0; i--) begin
      if (sync2_q[i]) begin
        raw_code = 4'(i + 1);
      end
      ones = ones + {3'b000, sync2_q[i]};
    end
    multi_d = (ones > 4'd1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      note_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      note_q   <= note_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    note_d   = note_q;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw_code != 4'd0) begin
          state_d = PRESS_WAIT;
          cand_d  = raw_code;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (raw_code == 4'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (raw_code != cand_q) begin
          cand_d = raw_code;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          note_d   = cand_q;
          strobe_d = 1'b1;
          state_d  = HELD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (raw_code != note_q) begin
          state_d = RELEASE_WAIT;
          cand_d  = raw_code;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A return to the held note is a glitch; a new stable code may be a release or a slide.
        if (raw_code == note_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (raw_code != cand_q) begin
          cand_d = raw_code;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          note_d   = cand_q;
          strobe_d = 1'b1;
          state_d  = (cand_q == 4'd0) ? IDLE : HELD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    note        = note_q;
    note_strobe = strobe_q;
    multi_key   = multi_q;
  end

endmodule

// File: tb/tb_note_key_debouncer.sv
// tb/tb_note_key_debouncer.sv - self-checking bench for note_key_debouncer
// Reference model: a note takes the raw code once it has been sampled unchanged for D+1 edges.
module tb_note_key_debouncer;

  localparam int D  = 4;
  localparam int CW = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] keys;
  logic [3:0] note;
  logic       note_strobe;
  logic       multi_key;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] m_s1, m_s2;
  int         run_val, run_len;
  logic [3:0] m_note;
  logic       m_strobe, m_multi;

  note_key_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .keys(keys),
    .note(note), .note_strobe(note_strobe), .multi_key(multi_key)
  );

  always #5 CLK = ~CLK;

  function automatic int code_of(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; run_val = 0; run_len = 0;
    m_note = '0; m_strobe = 1'b0; m_multi = 1'b0;
  endtask

  task automatic tick(input logic [7:0] k);
    int raw;
    keys = k;
    @(posedge CLK);
    raw = code_of(m_s2);
    if (raw == run_val) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_val = raw;
      run_len = 1;
    end
    m_strobe = 1'b0;
    if (run_len >= D + 1 && run_val != int'(m_note)) begin
      m_note   = 4'(run_val);
      m_strobe = 1'b1;
    end
    m_multi = ($countones(m_s2) > 1);
    m_s2 = m_s1;
    m_s1 = k;
    #1;
  endtask

  task automatic assert_reset();
    #2 RESET = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    chk_cnt++; if (note !== 4'd0) $display("FAIL reset_note got=%0d exp=0", note); else pass_cnt++;
    chk_cnt++; if (note_strobe !== 1'b0) $display("FAIL reset_strobe got=%b exp=0", note_strobe); else pass_cnt++;
    chk_cnt++; if (multi_key !== 1'b0) $display("FAIL reset_multi got=%b exp=0", multi_key); else pass_cnt++;
    release_reset();
  endtask

  task automatic test_clean_press();
    int at;
    for (int p = 0; p < 2; p++) begin
      at = -1;
      for (int i = 0; i < D + 6; i++) begin
        tick(p == 0 ? 8'h04 : 8'h00);
        if (note_strobe === 1'b1 && at < 0) at = i;
        chk_cnt++;
        if ({note, note_strobe, multi_key} !== {m_note, m_strobe, m_multi})
          $display("FAIL clean_track p=%0d i=%0d note=%0d/%0d strobe=%b/%b multi=%b/%b",
                   p, i, note, m_note, note_strobe, m_strobe, multi_key, m_multi);
        else pass_cnt++;
      end
      chk_cnt++; if (at != D + 2) $display("FAIL clean_latency p=%0d got=%0d exp=%0d", p, at, D + 2); else pass_cnt++;
      chk_cnt++; if (note !== (p == 0 ? 4'd3 : 4'd0)) $display("FAIL clean_note p=%0d got=%0d", p, note); else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    int strobes, at;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(((i / 2) % 2 == 0) ? 8'h01 : 8'h00);
      if (note_strobe === 1'b1) strobes++;
      chk_cnt++;
      if (note !== m_note || note_strobe !== m_strobe)
        $display("FAIL bounce_track i=%0d note=%0d/%0d strobe=%b/%b", i, note, m_note, note_strobe, m_strobe);
      else pass_cnt++;
    end
    chk_cnt++; if (strobes != 0 || note !== 4'd0) $display("FAIL bounce_quiet strobes=%0d note=%0d exp 0/0", strobes, note); else pass_cnt++;
    at = -1;
    for (int i = 0; i < D + 6; i++) begin
      tick(8'h01);
      if (note_strobe === 1'b1 && at < 0) at = i;
    end
    chk_cnt++; if (at != D + 2) $display("FAIL bounce_latency got=%0d exp=%0d", at, D + 2); else pass_cnt++;
    chk_cnt++; if (note !== 4'd1) $display("FAIL bounce_note got=%0d exp=1", note); else pass_cnt++;
  endtask

  task automatic test_release_glitch();
    int strobes, multi_seen;
    for (int i = 0; i < D + 6; i++) tick(8'h10);
    chk_cnt++; if (note !== 4'd5) $display("FAIL glitch_setup got=%0d exp=5", note); else pass_cnt++;
    strobes = 0; multi_seen = 0;
    for (int i = 0; i < D + 8; i++) begin
      tick((i == 0 || i == 1) ? 8'h00 : 8'h10);
      if (note_strobe !== 1'b0) strobes++;
      if (multi_key !== 1'b0) multi_seen++;
      chk_cnt++;
      if (note !== m_note || note !== 4'd5)
        $display("FAIL glitch_note i=%0d got=%0d model=%0d exp=5", i, note, m_note);
      else pass_cnt++;
    end
    chk_cnt++; if (strobes != 0 || multi_seen != 0)
      $display("FAIL glitch_quiet strobes=%0d multi=%0d exp 0/0", strobes, multi_seen); else pass_cnt++;
  endtask

  task automatic test_chord();
    logic m1, m2;
    int at, strobes;
    at = -1;
    for (int i = 0; i < D + 6; i++) begin
      tick(8'h24);
      if (i == 1) m1 = multi_key;
      if (i == 2) m2 = multi_key;
      if (note_strobe === 1'b1 && at < 0) at = i;
    end
    chk_cnt++; if (m1 !== 1'b0 || m2 !== 1'b1) $display("FAIL chord_multi_timing got=%b%b exp=01", m1, m2); else pass_cnt++;
    chk_cnt++; if (at != D + 2 || note !== 4'd3)
      $display("FAIL chord_priority at=%0d note=%0d exp=%0d/3", at, note, D + 2); else pass_cnt++;
    strobes = 0;
    for (int i = 0; i < D + 6; i++) begin
      tick(8'h20);
      if (note_strobe === 1'b1) strobes++;
    end
    chk_cnt++; if (strobes != 1 || note !== 4'd6 || multi_key !== 1'b0)
      $display("FAIL chord_drop strobes=%0d note=%0d multi=%b exp 1/6/0", strobes, note, multi_key); else pass_cnt++;
  endtask

  task automatic test_slide();
    int strobes, saw_zero;
    for (int i = 0; i < D + 6; i++) tick(8'h01);
    chk_cnt++; if (note !== 4'd1) $display("FAIL slide_setup got=%0d exp=1", note); else pass_cnt++;
    strobes = 0; saw_zero = 0;
    for (int i = 0; i < D + 6; i++) begin
      tick(8'h80);
      if (note_strobe === 1'b1) strobes++;
      if (note === 4'd0) saw_zero++;
    end
    chk_cnt++; if (strobes != 1 || saw_zero != 0 || note !== 4'd8)
      $display("FAIL slide strobes=%0d zero_cycles=%0d note=%0d exp 1/0/8", strobes, saw_zero, note); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int at;
    assert_reset();
    chk_cnt++; if (note !== 4'd0) $display("FAIL async_reset_note got=%0d exp=0", note); else pass_cnt++;
    release_reset();
    for (int i = 0; i < 5; i++) tick(8'h24);
    chk_cnt++; if (multi_key !== 1'b1 || note !== 4'd0)
      $display("FAIL mid_setup multi=%b note=%0d exp 1/0", multi_key, note); else pass_cnt++;
    assert_reset();
    chk_cnt++; if ({note, note_strobe, multi_key} !== 6'd0)
      $display("FAIL mid_reset note=%0d strobe=%b multi=%b exp 0/0/0", note, note_strobe, multi_key); else pass_cnt++;
    release_reset();
    at = -1;
    for (int i = 0; i < D + 6; i++) begin
      tick(8'h24);
      if (note_strobe === 1'b1 && at < 0) at = i;
    end
    chk_cnt++; if (at != D + 2 || note !== 4'd3)
      $display("FAIL mid_relatency at=%0d note=%0d exp=%0d/3", at, note, D + 2); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] pat;
    int len;
    pat = 8'h00;
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 3))
        0: pat = 8'h00;
        1: pat = 8'(1 << $urandom_range(0, 7));
        2: pat = 8'($urandom_range(0, 255));
        default: ;
      endcase
      len = $urandom_range(1, 2 * D + 3);
      for (int i = 0; i < len; i++) begin
        tick(pat);
        chk_cnt++;
        if ({note, note_strobe, multi_key} !== {m_note, m_strobe, m_multi})
          $display("FAIL random seg=%0d pat=%h note=%0d/%0d strobe=%b/%b multi=%b/%b",
                   seg, pat, note, m_note, note_strobe, m_strobe, multi_key, m_multi);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    keys  = 8'h00;
    RESET = 1'b1;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_chord();
    test_slide();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
